// File: rtl/ysyx_23060061_ifu_axi_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060061_ifu_axi_fetch
// Description : Instruction fetch unit. Issues single-outstanding AXI4-Lite
//               reads, buffers returned instructions in a small prefetch
//               FIFO and hands them to the IDU over a valid/ready handshake.
//               A redirect flushes the FIFO and discards any in-flight beat.
// Options     : IFU_ACCESS_FAULT_EN - tag error responses as inst_fault and
//               halt fetching until the next redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060061_ifu_axi_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [INST_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] C_STEP  = ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_drop;
    logic              r_halted;

    logic [INST_W-1:0] r_mem_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_issue;
    logic              w_ar_hs;
    logic              w_beat;
    logic              w_push;
    logic              w_pop;
    logic              w_fault;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and AXI handshake outputs; issue only with a free FIFO slot
    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        w_issue     = 1'b0;
        w_ar_hs     = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_halted && !redirect && (r_count < C_DEPTH)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_ar_hs     = 1'b1;
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_beat      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A beat is kept only if no redirect hit it, either earlier or right now
    assign w_push = w_beat && !r_drop && !redirect;
    assign w_pop  = inst_valid && inst_ready && !redirect;

    // The request address is frozen at issue so araddr stays put across a redirect
    assign araddr = r_req_addr;

    // Fetch PC, drop flag and fault halt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_drop     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req_addr <= r_fetch_pc;
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_halted   <= 1'b0;
            end else if (w_ar_hs && !r_drop) begin
                r_fetch_pc <= r_req_addr + C_STEP;
            end
            if (w_beat) begin
                r_drop <= 1'b0;
            end else if (redirect && ((r_state == ST_AR) || (r_state == ST_R))) begin
                r_drop <= 1'b1;
            end
            if (w_push && w_fault) begin
                r_halted <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage, written on each kept beat
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= rdata;
            r_mem_pc[r_wr_ptr]   <= r_req_addr;
        end
    end

    assign inst_valid = (r_count != '0);
    assign inst       = r_mem_inst[r_rd_ptr];
    assign inst_pc    = r_mem_pc[r_rd_ptr];

`ifdef IFU_ACCESS_FAULT_EN
    logic r_mem_fault [FIFO_DEPTH];

    assign w_fault = (rresp != 2'b00);

    // Fault tag travels with its instruction
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_fault[r_wr_ptr] <= w_fault;
        end
    end

    assign inst_fault = r_mem_fault[r_rd_ptr];
`else
    logic w_unused_rresp;

    assign w_unused_rresp = ^rresp;
    assign w_fault        = 1'b0;
    assign inst_fault     = 1'b0;
`endif

endmodule
`default_nettype wire
